// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing generator with pixel-rate divider
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_VIS_START = 144,
    parameter int unsigned H_VIS_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_VIS_START = 35,
    parameter int unsigned V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pixel_en,
    output logic       frame_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_VS     = 10'(H_VIS_START);
    localparam logic [9:0] H_VE     = 10'(H_VIS_END);
    localparam logic [9:0] V_VS     = 10'(V_VIS_START);
    localparam logic [9:0] V_VE     = 10'(V_VIS_END);

    logic [3:0] div;
    logic [3:0] div_nxt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       step;
    logic       h_wrap;
    logic       v_wrap;

    always_comb begin
        step    = (div == DIV_LAST);
        div_nxt = step ? 4'd0 : div + 4'd1;
        h_wrap  = (hCount == H_LAST);
        v_wrap  = (vCount == V_LAST);
        h_nxt   = hCount;
        v_nxt   = vCount;
        if (step) begin
            if (h_wrap) begin
                h_nxt = 10'd0;
                v_nxt = v_wrap ? 10'd0 : vCount + 10'd1;
            end else begin
                h_nxt = hCount + 10'd1;
            end
        end
    end

    // Decode from next-state counters so syncs/bright line up with hCount/vCount.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div        <= 4'd0;
            hCount     <= 10'd0;
            vCount     <= 10'd0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            pixel_en   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            div        <= div_nxt;
            hCount     <= h_nxt;
            vCount     <= v_nxt;
            hSync      <= !(h_nxt < H_SYNC_W);
            vSync      <= !(v_nxt < V_SYNC_W);
            bright     <= (h_nxt >= H_VS) && (h_nxt < H_VE) &&
                          (v_nxt >= V_VS) && (v_nxt < V_VE);
            pixel_en   <= (div_nxt == DIV_LAST);
            frame_tick <= step && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized reset/run bench against closed-form raster model
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: default geometry; 1: small geometry, div 4; 2: small geometry, div 1
    logic [9:0] hc0, vc0, hc1, vc1, hc2, vc2;
    logic       hs0, vs0, br0, pe0, ft0;
    logic       hs1, vs1, br1, pe1, ft1;
    logic       hs2, vs2, br2, pe2, ft2;

    vga_timing_gen u_dut0 (
        .clk(clk), .reset_n(reset_n), .hCount(hc0), .vCount(vc0), .hSync(hs0),
        .vSync(vs0), .bright(br0), .pixel_en(pe0), .frame_tick(ft0)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_TOTAL(40), .H_SYNC(5), .H_VIS_START(8), .H_VIS_END(36),
        .V_TOTAL(20), .V_SYNC(2), .V_VIS_START(4), .V_VIS_END(18)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .hCount(hc1), .vCount(vc1), .hSync(hs1),
        .vSync(vs1), .bright(br1), .pixel_en(pe1), .frame_tick(ft1)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(40), .H_SYNC(5), .H_VIS_START(8), .H_VIS_END(36),
        .V_TOTAL(20), .V_SYNC(2), .V_VIS_START(4), .V_VIS_END(18)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .hCount(hc2), .vCount(vc2), .hSync(hs2),
        .vSync(vs2), .bright(br2), .pixel_en(pe2), .frame_tick(ft2)
    );

    int     n_chk  = 0;
    int     n_pass = 0;
    longint k      = 0;
    bit     first_run = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t k=%0d: got %h expected %h", tag, $time, k, got, exp);
            if (n_chk - n_pass >= 30) begin
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
        end
    endtask

    // Position after k edges since release is simply floor(k/div) pixels into the raster.
    function automatic logic [31:0] model(input longint d, input longint h, input longint hs,
                                          input longint hvs, input longint hve, input longint v,
                                          input longint vs, input longint vvs, input longint vve,
                                          input longint kk);
        longint pos, hc, vc;
        logic   e_hs, e_vs, e_br, e_pe, e_ft;
        pos  = (kk / d) % (h * v);
        hc   = pos % h;
        vc   = pos / h;
        e_hs = !(hc < hs);
        e_vs = !(vc < vs);
        e_br = (hc >= hvs) && (hc < hve) && (vc >= vvs) && (vc < vve);
        e_pe = (kk > 0) && ((kk % d) == d - 1);
        e_ft = (kk > 0) && ((kk % (d * h * v)) == 0);
        return {7'd0, 10'(hc), 10'(vc), e_hs, e_vs, e_br, e_pe, e_ft};
    endfunction

    task automatic check_all();
        check_eq("dflt_div4", {7'd0, hc0, vc0, hs0, vs0, br0, pe0, ft0},
                 model(4, 800, 96, 144, 784, 525, 2, 35, 515, k));
        check_eq("small_div4", {7'd0, hc1, vc1, hs1, vs1, br1, pe1, ft1},
                 model(4, 40, 5, 8, 36, 20, 2, 4, 18, k));
        check_eq("small_div1", {7'd0, hc2, vc2, hs2, vs2, br2, pe2, ft2},
                 model(1, 40, 5, 8, 36, 20, 2, 4, 18, k));
        if (first_run && k == 3) check_eq("first_pixel_en_edge3", 32'(pe0), 32'd1);
        if (first_run && k == 4) check_eq("first_hcount1_edge4", 32'(hc0), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) k++;
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset between edges, check it lands with no clock edge, hold, then release.
    task automatic pulse_reset(input int hold);
        #($urandom_range(1, 3));
        reset_n = 1'b0;
        k = 0;
        #1;
        check_all();
        run(hold);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        k = 0;
        run(10);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        run(3300);
        first_run = 1'b0;
        // mid-frame abort at a known position of the small raster, then rerun from scratch
        pulse_reset(1);
        run(40 * 12 * 4 + 17 * 4);
        pulse_reset(1);
        for (int it = 0; it < 6; it++) begin
            run($urandom_range(200, 4000));
            pulse_reset($urandom_range(1, 3));
        end
        run(7000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA path. It divides the 100 MHz board clock down to the 25 MHz pixel rate and runs the horizontal and vertical pixel counters. It produces registered active-low sync pulses, the `bright` visible-area flag and a once-per-frame tick. Its `hCount`, `vCount` and `bright` outputs feed `vga_bitchange` directly, and `frame_tick` paces game-object motion.

## Interface

Parameters:
- `CLK_DIV`, 4, clk cycles per pixel; legal range 1..16.
- `H_TOTAL`, 800, pixels per line.
- `H_SYNC`, 96, hSync low width, in pixels, starting at hCount 0.
- `H_VIS_START`, 144, first visible hCount.
- `H_VIS_END`, 784, first non-visible hCount after the visible region.
- `V_TOTAL`, 525, lines per frame.
- `V_SYNC`, 2, vSync low width, in lines, starting at vCount 0.
- `V_VIS_START`, 35, first visible vCount.
- `V_VIS_END`, 515, first non-visible vCount after the visible region.

Ports:
- `clk` in 1: system clock, 100 MHz. The block uses this one clock only.
- `reset_n` in 1: asynchronous, active-low reset.
- `hCount` out 10: current pixel column, 0..H_TOTAL-1.
- `vCount` out 10: current line, 0..V_TOTAL-1.
- `hSync` out 1: horizontal sync, active low.
- `vSync` out 1: vertical sync, active low.
- `bright` out 1: high while (hCount, vCount) is inside the visible window.
- `pixel_en` out 1: one-clk pulse in the cycle before the counters advance.
- `frame_tick` out 1: one-clk pulse in the cycle in which the counters become (0, 0).

## Operation

- **Divider.** `div` counts 0..CLK_DIV-1 and wraps, advancing every clk. The divider is 4 bits wide.
- **pixel_en.** Registered: `pixel_en` is high exactly while `div == CLK_DIV-1`. With CLK_DIV = 1 it is constantly high after reset.
- **Counter advance.** On each clk edge where `div == CLK_DIV-1`:
  - If hCount == H_TOTAL-1: hCount goes to 0 and vCount advances.
  - Otherwise hCount goes to hCount+1.
- **Vertical advance.** vCount goes to 0 when vCount == V_TOTAL-1, otherwise to vCount+1.
- **Sync and bright decode.** `hSync`, `vSync` and `bright` are registered. They are decoded from the next-state counter values, so they change on the same edge as the counters and are always consistent with the current hCount/vCount:
  - hSync = 0 when hCount < H_SYNC.
  - vSync = 0 when vCount < V_SYNC.
  - bright = (H_VIS_START <= hCount < H_VIS_END) && (V_VIS_START <= vCount < V_VIS_END).
- **frame_tick.** Registered. Set high on the edge where both counters wrap to 0; low on every other edge.
- **Widths.** All counter comparisons are unsigned 10-bit. Neither counter ever holds a value at or above its TOTAL.
- **Reset.** When reset_n is asserted, the following take effect asynchronously:
  - div = 0, hCount = 0, vCount = 0.
  - hSync = 0 and vSync = 0 (consistent with counters at 0).
  - bright = 0, pixel_en = 0, frame_tick = 0.
- **Reset mid-frame.** Asserting reset mid-frame aborts the frame immediately; no partial-line completion. After release, counting restarts from (0, 0) and no frame_tick is generated for that restart.

## Timing

- **First step after release.** The first rising edge after reset_n deasserts takes div from 0 to 1.
  - With CLK_DIV = 4, hCount first becomes 1 on the 4th edge after release.
  - pixel_en is high on edge 3 and low again on edge 4.
- **Periods (default parameters):**
  - pixel = 4 clk.
  - line = 3200 clk.
  - frame = 1,680,000 clk (59.52 Hz).
- **Pulse widths (default parameters):**
  - hSync low for 384 clk per line.
  - vSync low for 6400 clk per frame.
  - bright high for 2560 clk on each of lines 35..514.
- **Latency.** Output latency relative to the counters is 0: hSync, vSync and bright are valid on the same edge as the hCount/vCount values they describe.
- **Downstream use.** `vga_bitchange` consumes these outputs combinationally.
- **Wrap-around.** At (H_TOTAL-1, V_TOTAL-1) a single edge produces all of the following:
  - hCount = 0 and vCount = 0.
  - hSync = 0 and vSync = 0.
  - bright = 0.
  - frame_tick = 1.
- **frame_tick spacing.** Exactly one frame_tick per frame: H_TOTAL × V_TOTAL × CLK_DIV clk between consecutive pulses.

## Test plan

- **Reset and first step.** Hold reset_n low for 10 clk, then release.
  - Outputs read 0 throughout reset.
  - hCount = 1 first appears 4 clk after release.
  - pixel_en pulses on edge 3.
- **Horizontal timing.** Run one full line.
  - hSync is low for exactly 384 clk, then high for 2816 clk.
  - hCount wraps 799 → 0 and vCount increments by 1 on that same edge.
- **Visible-window edges.** Check bright at the window corners.
  - Low at (143, 35).
  - High at (144, 35).
  - High at (783, 514).
  - Low at (784, 514).
  - Low at (144, 515).
  - Low everywhere on lines 0..34.
- **Frame timing.** Run two frames.
  - frame_tick pulses are exactly 1,680,000 clk apart and 1 clk wide.
  - vSync is low for 6400 clk starting when vCount becomes 0.
- **Reset mid-frame.** Assert reset_n at (400, 300) for 1 clk.
  - All outputs go to their reset values immediately, without waiting for a clk edge.
  - After release, normal counting resumes from (0, 0) with no spurious frame_tick.
- **CLK_DIV = 1 build.**
  - pixel_en stays high after reset.
  - hCount advances every clk.
  - Line = 800 clk; frame = 420,000 clk.
